// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings: instruction
// memory port, downstream control (stall/redirect/interrupt) and the IF/ID entry.
interface fetch_stage_if;
    logic        interruptSignal;
    logic        stall;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_imm;
    logic        ifid_has_imm;
    logic [15:0] ifid_pc;
    logic        ifid_valid;
    logic        ifid_int;
    logic        int_ack;

    // Fetch-stage side.
    modport master (
        input  interruptSignal,
        input  stall,
        input  redirect_en,
        input  redirect_pc,
        input  imem_data,
        output imem_addr,
        output ifid_instr,
        output ifid_imm,
        output ifid_has_imm,
        output ifid_pc,
        output ifid_valid,
        output ifid_int,
        output int_ack
    );

    // Environment side: memory, decode stage and interrupt source.
    modport slave (
        output interruptSignal,
        output stall,
        output redirect_en,
        output redirect_pc,
        output imem_data,
        input  imem_addr,
        input  ifid_instr,
        input  ifid_imm,
        input  ifid_has_imm,
        input  ifid_pc,
        input  ifid_valid,
        input  ifid_int,
        input  int_ack
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the MZNM pipeline. Owns the PC, merges two-word
// (LDM) instructions with their immediate into one IF/ID entry, injects an
// interrupt pseudo-instruction and applies stalls and redirects.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] INT_VECTOR = 16'h0010,
    parameter logic [4:0]  IMM_OPCODE = 5'b01100,
    parameter logic [4:0]  INT_OPCODE = 5'b11111
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);

    typedef enum logic {StFetch, StImm} fetchState_e;

    fetchState_e stateQ;
    logic [15:0] pcQ;
    logic [15:0] holdQ;
    logic        intPendingQ;
    logic        intPrevQ;

    logic [15:0] pcPlusOne;
    logic        intEdge;
    logic        isTwoWord;

    // PC+1 wraps naturally at 16 bits, so the immediate after FFFF comes from 0000.
    assign pcPlusOne     = pcQ + 16'd1;
    assign intEdge       = bus.interruptSignal & ~intPrevQ;
    assign isTwoWord     = (bus.imem_data[15:11] == IMM_OPCODE);
    assign bus.imem_addr = pcQ;

    // PC, fetch state, interrupt capture and the registered IF/ID entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ           <= StFetch;
            pcQ              <= RESET_PC;
            holdQ            <= 16'h0000;
            intPendingQ      <= 1'b0;
            intPrevQ         <= 1'b0;
            bus.ifid_instr   <= 16'h0000;
            bus.ifid_imm     <= 16'h0000;
            bus.ifid_has_imm <= 1'b0;
            bus.ifid_pc      <= 16'h0000;
            bus.ifid_valid   <= 1'b0;
            bus.ifid_int     <= 1'b0;
            bus.int_ack      <= 1'b0;
        end else begin
            // Edge detection runs every cycle, stalled or not.
            intPrevQ    <= bus.interruptSignal;
            bus.int_ack <= 1'b0;
            if (intEdge) begin
                intPendingQ <= 1'b1;
            end

            if (bus.redirect_en) begin
                // Redirect beats stall and interrupt; a half-fetched LDM is dropped.
                pcQ              <= bus.redirect_pc;
                stateQ           <= StFetch;
                bus.ifid_valid   <= 1'b0;
                bus.ifid_int     <= 1'b0;
                bus.ifid_has_imm <= 1'b0;
            end else if (bus.stall) begin
                // Hold everything; only the interrupt capture above advances.
            end else if (stateQ == StFetch && intPendingQ) begin
                // The instruction at PC is not consumed; it becomes the return point.
                bus.ifid_instr   <= {INT_OPCODE, 11'b0};
                bus.ifid_int     <= 1'b1;
                bus.ifid_valid   <= 1'b1;
                bus.ifid_has_imm <= 1'b0;
                bus.ifid_pc      <= pcQ;
                pcQ              <= INT_VECTOR;
                intPendingQ      <= 1'b0;
                bus.int_ack      <= 1'b1;
            end else if (stateQ == StFetch && isTwoWord) begin
                // First word of an LDM: park it and emit a bubble.
                holdQ          <= bus.imem_data;
                pcQ            <= pcPlusOne;
                stateQ         <= StImm;
                bus.ifid_valid <= 1'b0;
                bus.ifid_int   <= 1'b0;
            end else if (stateQ == StFetch) begin
                bus.ifid_instr   <= bus.imem_data;
                bus.ifid_valid   <= 1'b1;
                bus.ifid_has_imm <= 1'b0;
                bus.ifid_int     <= 1'b0;
                bus.ifid_pc      <= pcPlusOne;
                pcQ              <= pcPlusOne;
            end else begin
                // Second word: merge with the parked first word.
                bus.ifid_instr   <= holdQ;
                bus.ifid_imm     <= bus.imem_data;
                bus.ifid_has_imm <= 1'b1;
                bus.ifid_valid   <= 1'b1;
                bus.ifid_int     <= 1'b0;
                bus.ifid_pc      <= pcPlusOne;
                pcQ              <= pcPlusOne;
                stateQ           <= StFetch;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a cycle-level reference model.
module tb_fetch_stage;

    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam logic [15:0] INT_VECTOR = 16'h0010;
    localparam logic [4:0]  IMM_OPCODE = 5'b01100;
    localparam logic [4:0]  INT_OPCODE = 5'b11111;

    logic clk;
    logic reset;
    fetch_stage_if bus ();

    logic [15:0] mem [65536];

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model state: what the IF/ID entry and PC should be.
    logic [15:0] mPc, mHold, mInstr, mImm, mIfPc;
    logic        mInImm, mPending, mIrqPrev;
    logic        mValid, mInt, mHasImm, mAck;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .INT_VECTOR(INT_VECTOR),
        .IMM_OPCODE(IMM_OPCODE),
        .INT_OPCODE(INT_OPCODE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = RESET_PC; mHold = 16'h0; mInstr = 16'h0; mImm = 16'h0; mIfPc = 16'h0;
        mInImm = 1'b0; mPending = 1'b0; mIrqPrev = 1'b0;
        mValid = 1'b0; mInt = 1'b0; mHasImm = 1'b0; mAck = 1'b0;
    endtask

    // Advance the model by one clock edge given the inputs held across that edge.
    task automatic modelStep(input logic st, input logic rd, input logic [15:0] rdPc,
                             input logic irq);
        logic [15:0] word;
        logic        rose;
        logic        taken;
        word  = mem[mPc];
        rose  = irq && !mIrqPrev;
        taken = 1'b0;
        mIrqPrev = irq;
        mAck = 1'b0;
        if (rd) begin
            mPc = rdPc; mInImm = 1'b0;
            mValid = 1'b0; mInt = 1'b0; mHasImm = 1'b0;
        end else if (st) begin
            // frozen
        end else if (mInImm) begin
            mInstr = mHold; mImm = word; mHasImm = 1'b1; mValid = 1'b1; mInt = 1'b0;
            mPc = mPc + 16'd1; mIfPc = mPc; mInImm = 1'b0;
        end else if (mPending) begin
            mInstr = {INT_OPCODE, 11'b0}; mInt = 1'b1; mValid = 1'b1; mHasImm = 1'b0;
            mIfPc = mPc; mPc = INT_VECTOR; mAck = 1'b1; taken = 1'b1;
        end else if (word[15:11] == IMM_OPCODE) begin
            mHold = word; mPc = mPc + 16'd1; mInImm = 1'b1; mValid = 1'b0; mInt = 1'b0;
        end else begin
            mInstr = word; mValid = 1'b1; mHasImm = 1'b0; mInt = 1'b0;
            mPc = mPc + 16'd1; mIfPc = mPc;
        end
        // A rising edge while already pending is absorbed.
        if (taken) mPending = 1'b0;
        else if (rose) mPending = 1'b1;
    endtask

    task automatic compareAll();
        checkVal("imem_addr", bus.imem_addr, mPc);
        checkVal("ifid_valid", {15'b0, bus.ifid_valid}, {15'b0, mValid});
        checkVal("ifid_int", {15'b0, bus.ifid_int}, {15'b0, mInt});
        checkVal("ifid_has_imm", {15'b0, bus.ifid_has_imm}, {15'b0, mHasImm});
        checkVal("int_ack", {15'b0, bus.int_ack}, {15'b0, mAck});
        checkVal("ifid_instr", bus.ifid_instr, mInstr);
        checkVal("ifid_imm", bus.ifid_imm, mImm);
        checkVal("ifid_pc", bus.ifid_pc, mIfPc);
    endtask

    // Drive inputs just after an edge, let one edge pass, then compare.
    task automatic driveCycle(input logic st, input logic rd, input logic [15:0] rdPc,
                              input logic irq);
        bus.stall           = st;
        bus.redirect_en     = rd;
        bus.redirect_pc     = rdPc;
        bus.interruptSignal = irq;
        modelStep(st, rd, rdPc, irq);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        logic        irqLvl;
        logic        st, rd;
        logic [15:0] rp;
        logic [15:0] w;
        int          acks;
        bit          midReset;

        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:11] = IMM_OPCODE;
            mem[i] = w;
        end
        mem[0] = 16'hD000; mem[1] = 16'hD100; mem[2] = 16'h0000;
        mem[3] = 16'h2100;

        reset = 1'b1;
        bus.stall = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = 16'h0;
        bus.interruptSignal = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        compareAll();
        reset = 1'b0;

        // Straight-line start: D000, D100, 0000.
        driveCycle(1'b0, 1'b0, 16'h0, 1'b0);
        checkVal("seq0_instr", bus.ifid_instr, 16'hD000);
        checkVal("seq0_pc", bus.ifid_pc, 16'h0001);
        driveCycle(1'b0, 1'b0, 16'h0, 1'b0);
        checkVal("seq1_instr", bus.ifid_instr, 16'hD100);
        driveCycle(1'b0, 1'b0, 16'h0, 1'b0);
        checkVal("seq2_pc", bus.ifid_pc, 16'h0003);
        checkVal("seq2_addr", bus.imem_addr, 16'h0003);

        // Stall holds everything, including the address.
        for (int i = 0; i < 3; i++) driveCycle(1'b1, 1'b0, 16'h0, 1'b0);
        checkVal("stall_addr", bus.imem_addr, 16'h0003);

        // Single interrupt edge held high yields exactly one ack.
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            driveCycle(1'b0, 1'b0, 16'h0, (i >= 1) ? 1'b1 : 1'b0);
            if (bus.int_ack === 1'b1) acks++;
        end
        checkVal("ack_once", 16'(acks), 16'd1);
        for (int i = 0; i < 4; i++) driveCycle(1'b0, 1'b0, 16'h0, 1'b0);

        // Randomized phase, with one asynchronous reset landing between LDM words.
        irqLvl = 1'b0;
        midReset = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!midReset && cyc > 1500 && mInImm) begin
                midReset = 1'b1;
                reset = 1'b1;
                #1;
                modelReset();
                compareAll();
                @(posedge clk);
                #1;
                reset = 1'b0;
                compareAll();
            end
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(0, 5) == 0) irqLvl = ~irqLvl;
            driveCycle(st, rd, rp, irqLvl);
        end
        checkVal("mid_reset_hit", {15'b0, midReset}, 16'd1);

        // Drain any pending interrupt, then test PC wrap through an LDM at FFFF.
        for (int i = 0; i < 4; i++) driveCycle(1'b0, 1'b0, 16'h0, 1'b0);
        mem[16'hFFFF] = 16'h6123;
        mem[16'h0000] = 16'hABCD;
        driveCycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
        driveCycle(1'b0, 1'b0, 16'h0, 1'b0);
        checkVal("wrap_bubble", {15'b0, bus.ifid_valid}, 16'd0);
        driveCycle(1'b0, 1'b0, 16'h0, 1'b0);
        checkVal("wrap_instr", bus.ifid_instr, 16'h6123);
        checkVal("wrap_imm", bus.ifid_imm, 16'hABCD);
        checkVal("wrap_pc", bus.ifid_pc, 16'h0001);
        checkVal("wrap_has_imm", {15'b0, bus.ifid_has_imm}, 16'd1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit MZNM pipeline; sits directly upstream of the decode stage inside the Controller and feeds the IF/ID register.
- Owns the PC and drives the instruction-memory address.
- Merges LDM-style two-word instructions with their immediate word into a single IF/ID entry.
- Injects an interrupt pseudo-instruction on an external interrupt edge and applies stalls and branch/CALL/RET redirects from downstream.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- INT_VECTOR, 16'h0010, PC loaded when an interrupt is taken.
- IMM_OPCODE, 5'b01100, instr[15:11] value marking a two-word instruction (LDM).
- INT_OPCODE, 5'b11111, instr[15:11] of the injected interrupt pseudo-instruction.

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high reset.
- interruptSignal  in  1  External interrupt request; only the rising edge is used.
- stall  in  1  Hazard stall from decode; holds PC, state and IF/ID.
- redirect_en  in  1  Taken branch/CALL/RET/jump from downstream.
- redirect_pc  in  16  Redirect target.
- imem_addr  out  16  Instruction-memory address, combinational, equals PC.
- imem_data  in  16  Instruction word at imem_addr, available in the same cycle (asynchronous read).
- ifid_instr  out  16  Registered instruction.
- ifid_imm  out  16  Registered immediate word, valid when ifid_has_imm=1.
- ifid_has_imm  out  1  Entry carries an immediate.
- ifid_pc  out  16  Registered next-sequential PC: the return address for CALL and for interrupts.
- ifid_valid  out  1  Entry is a real instruction; 0 = bubble.
- ifid_int  out  1  Entry is the interrupt pseudo-instruction.
- int_ack  out  1  One-cycle pulse when an interrupt is taken.

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC; state=FETCH.
  - All ifid_* outputs = 0; int_ack=0; int_pending=0; int_prev=0.
- int_prev <= interruptSignal every cycle, including during stall.
- int_pending is set when interruptSignal=1 and int_prev=0. Further edges while pending are ignored; one request is serviced per pending interval.
- int_ack defaults to 0 every cycle.
- Cycle priority, evaluated each edge:
  1. redirect_en=1:
     - PC<=redirect_pc; state<=FETCH; held first word discarded.
     - ifid_valid<=0, ifid_int<=0, ifid_has_imm<=0.
     - Overrides both stall and interrupt; int_pending is kept.
  2. stall=1: PC, state, hold register and all ifid_* are unchanged (int_pending capture still active).
  3. state=FETCH and int_pending=1:
     - ifid_instr<={INT_OPCODE,11'b0}; ifid_int<=1; ifid_valid<=1; ifid_has_imm<=0.
     - ifid_pc<=PC (the unfetched instruction is the return point).
     - PC<=INT_VECTOR; int_pending<=0; int_ack<=1.
  4. state=FETCH and imem_data[15:11]==IMM_OPCODE:
     - hold<=imem_data; PC<=PC+1; state<=IMM.
     - ifid_valid<=0 (bubble); ifid_int<=0.
  5. state=FETCH, other opcodes:
     - ifid_instr<=imem_data; ifid_valid<=1; ifid_has_imm<=0; ifid_int<=0.
     - ifid_pc<=PC+1; PC<=PC+1.
  6. state=IMM:
     - ifid_instr<=hold; ifid_imm<=imem_data; ifid_has_imm<=1; ifid_valid<=1; ifid_int<=0.
     - ifid_pc<=PC+1; PC<=PC+1; state<=FETCH.
     - A pending interrupt waits until back in FETCH; it is never taken between the two words.
- Latency: single-word instruction appears on IF/ID 1 cycle after its address is presented. A two-word instruction appears 2 cycles after its first address, preceded by one bubble.
- Arithmetic: PC+1 is modulo 2^16 (16'hFFFF -> 16'h0000). In IMM state the immediate is fetched from the wrapped address.
- ifid_imm is updated only in the IMM state and otherwise holds its last value.
- Reset asserted mid-IMM: the held word is lost and the stage restarts at RESET_PC.

Test Plan:
- Reset, memory 0:D000, 1:D100, 2:0000 -> imem_addr 0,1,2,3 on successive cycles; IF/ID shows D000/pc 1, D100/pc 2, 0000/pc 3; all valid=1.
- LDM at 5 (6500), immediate at 6 (0006) -> one bubble (valid=0), then ifid_instr=6500, ifid_imm=0006, has_imm=1, ifid_pc=7; next fetch address 7.
- stall=1 for 3 cycles while IF/ID holds 2100 at pc=4 -> imem_addr stays 4 and IF/ID stays unchanged; fetch resumes at 4 once stall drops.
- Rising interruptSignal while PC=8 in FETCH -> next edge: ifid_instr=F800, ifid_int=1, ifid_pc=8, int_ack pulses once, PC=16'h0010. Holding interruptSignal high causes no second ack.
- Interrupt edge while in IMM state; separately, redirect_en=1 with stall=1 and redirect_pc=0034 -> the interrupt is taken only after the LDM pair is emitted. The redirect loads PC=0034 with a bubble despite the stall, and any pending interrupt is taken on the following cycle.
- PC=FFFF holding an LDM opcode -> immediate is read from address 0000; ifid_pc=0001.
